// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter and its region decoder.
package imem_arb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [11:0] REGION_BOOT  = 12'h9fc;
    localparam logic [11:0] REGION_KSEG0 = 12'h800;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_cmd_t;
endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch port, data port and memory-side bus of the instruction-memory arbiter.
interface imem_arbiter_if;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid, if_rsp_err;
    logic [31:0] if_rsp_data;

    logic        d_req_valid, d_req_ready, d_req_we;
    logic [31:0] d_req_addr, d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_rsp_valid, d_rsp_err;
    logic [31:0] d_rsp_data;

    logic        mem_req, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    // master: the arbiter itself
    modport master (
        input  if_req_valid, if_req_addr,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wstrb, d_req_wdata,
        input  mem_rvalid, mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        output mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata
    );

    modport slave (
        output if_req_valid, if_req_addr,
        output d_req_valid, d_req_addr, d_req_we, d_req_wstrb, d_req_wdata,
        output mem_rvalid, mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/mem_region_dec.sv
// Address decode for the boot and kseg0 instruction-memory regions.
module mem_region_dec
    import imem_arb_pkg::*;
#(
    parameter int NMEM = 256
) (
    input  logic [31:0] addr,
    output logic        hit
);
    logic unused_byte_off;
    assign unused_byte_off = ^addr[1:0];

    assign hit = ((addr[31:20] == REGION_BOOT) || (addr[31:20] == REGION_KSEG0)) &&
                 (32'(addr[19:2]) < 32'(NMEM));
endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter between fetch and data ports in front of a single instruction memory,
// one outstanding transaction, with decode-error and timeout responses.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int NMEM    = 256
) (
    input  logic          clk,
    input  logic          resetn,
    imem_arbiter_if.master bus
);
    state_t   state, nstate;
    logic     last_grant, own_q;
    mem_cmd_t cmd_q, cmd_sel;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        sel_d, hs, hit, timeout, rsp;

    // Data wins when it is alone or when fetch was served last.
    assign sel_d   = bus.d_req_valid && (!bus.if_req_valid || last_grant == OWN_IF);
    assign hs      = resetn && (state == IDLE) && (bus.if_req_valid || bus.d_req_valid);
    assign timeout = (cnt == 8'(TIMEOUT - 1));

    assign bus.if_req_ready = hs && !sel_d;
    assign bus.d_req_ready  = hs && sel_d;

    always_comb begin
        cmd_sel = '0;
        if (sel_d) begin
            cmd_sel.addr  = bus.d_req_addr;
            cmd_sel.we    = bus.d_req_we;
            cmd_sel.wstrb = bus.d_req_wstrb;
            cmd_sel.wdata = bus.d_req_wdata;
        end else begin
            cmd_sel.addr  = bus.if_req_addr;
        end
    end

    mem_region_dec #(.NMEM(NMEM)) u_dec (.addr(cmd_sel.addr), .hit(hit));

    always_comb begin
        nstate = state;
        case (state)
            IDLE: if (hs) nstate = hit ? WAIT : RESP;
            WAIT: if (bus.mem_rvalid || timeout) nstate = RESP;
            RESP: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= OWN_D;
            own_q      <= OWN_IF;
            cmd_q      <= '0;
            cnt        <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= nstate;
            case (state)
                IDLE: if (hs) begin
                    last_grant <= sel_d ? OWN_D : OWN_IF;
                    own_q      <= sel_d ? OWN_D : OWN_IF;
                    cmd_q      <= cmd_sel;
                    cnt        <= '0;
                    rdata_q    <= '0;
                    err_q      <= !hit;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    // completion takes priority over a coincident timeout
                    if (bus.mem_rvalid) begin
                        rdata_q <= cmd_q.we ? 32'h0 : bus.mem_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = (state == WAIT);
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_wstrb = cmd_q.wstrb;
    assign bus.mem_wdata = cmd_q.wdata;

    assign rsp              = (state == RESP);
    assign bus.if_rsp_valid = rsp && (own_q == OWN_IF);
    assign bus.d_rsp_valid  = rsp && (own_q == OWN_D);
    assign bus.if_rsp_data  = bus.if_rsp_valid ? rdata_q : 32'h0;
    assign bus.d_rsp_data   = bus.d_rsp_valid  ? rdata_q : 32'h0;
    assign bus.if_rsp_err   = bus.if_rsp_valid && err_q;
    assign bus.d_rsp_err    = bus.d_rsp_valid  && err_q;
endmodule
